spi_sprite_link: RTL

SPI_SPRITE_LINK -- requirements
Module: spi_sprite_link

---
 rtl/spi_sprite_link_if.sv | 32 +++
 rtl/spi_sprite_link.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sprite_link_if.sv
// Sprite storage write bus and draw-queue read port.
// slave: link side (drives writes, queue head/status); master: consumer (drives dequeue).
interface spi_sprite_link_if #(
    parameter int SEL_W  = 4,
    parameter int ADDR_W = 12
);
    logic              sprite_w_en;
    logic [SEL_W-1:0]  sprite_w_select;
    logic [ADDR_W-1:0] sprite_w_addr;
    logic [7:0]        sprite_w_data;
    logic              dequeue;
    logic              is_empty;
    logic              is_full;
    logic [7:0]        sprite_id;
    logic [15:0]       sprite_x;
    logic [15:0]       sprite_y;
    logic [7:0]        sprite_scale;

    modport slave (
        output sprite_w_en, sprite_w_select, sprite_w_addr, sprite_w_data,
        output is_empty, is_full,
        output sprite_id, sprite_x, sprite_y, sprite_scale,
        input  dequeue
    );

    modport master (
        input  sprite_w_en, sprite_w_select, sprite_w_addr, sprite_w_data,
        input  is_empty, is_full,
        input  sprite_id, sprite_x, sprite_y, sprite_scale,
        output dequeue
    );
endinterface

// File: rtl/spi_sprite_link.sv
// SPI (mode 0) slave that loads sprite storage and feeds a draw-entry FIFO.
// Ports: clock/reset_n, async spi_clk/spi_cs/spi_mosi, bus (slave), overflow, frame_error.
module spi_sprite_link #(
    parameter int SPRITE_NUM  = 16,
    parameter int ADDR_W      = 12,
    parameter int QUEUE_DEPTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic spi_mosi,
    spi_sprite_link_if.slave bus,
    output logic overflow,
    output logic frame_error
);
    localparam int SEL_W = $clog2(SPRITE_NUM);
    localparam int PW    = $clog2(QUEUE_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [2:0] {
        IDLE, CMD, ENQ, WSEL, WADDR, WDATA, DISCARD
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] clk_sr, cs_sr, mosi_sr;
    logic sclk_s, cs_s, mosi_s, sclk_q, cs_q;
    logic sclk_rise, cs_fall, cs_rise, sample, byte_valid;
    logic [2:0] bit_cnt, byte_cnt;
    logic [6:0] shreg;
    logic [7:0] rx_byte, a_hi;
    logic [39:0] e_buf;
    logic [47:0] entry, head;
    logic [SEL_W-1:0] sel, w_sel_r;
    logic [ADDR_W-1:0] addr, w_addr_r;
    logic [7:0] w_data_r;
    logic w_en_r;
    logic push, clr, err_n, partial;

    logic [47:0] mem [QUEUE_DEPTH];
    logic [PW-1:0] rptr, wptr, rnext;
    logic [CW-1:0] count;
    logic empty, full, pop, push_ok, drop;

    // cs chain resets low so a frame already running at release never
    // produces a falling edge; only a fresh cs fall starts a frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sr  <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            clk_sr  <= {clk_sr[SYNC_STAGES-2:0], spi_clk};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sclk_q  <= sclk_s;
            cs_q    <= cs_s;
        end
    end

    assign sclk_s     = clk_sr[SYNC_STAGES-1];
    assign cs_s       = cs_sr[SYNC_STAGES-1];
    assign mosi_s     = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_q;
    assign cs_fall    = ~cs_s & cs_q;
    assign cs_rise    = cs_s & ~cs_q;
    assign sample     = sclk_rise & ~cs_s & (state != IDLE);
    assign byte_valid = sample & (bit_cnt == 3'd7);
    assign rx_byte    = {shreg, mosi_s};
    assign entry      = {e_buf, rx_byte};
    assign partial    = (bit_cnt != 3'd0) ||
                        (((state == ENQ) || (state == WADDR)) &&
                         (byte_cnt != 3'd0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (cs_fall) begin
            state_n = CMD;
        end else if (cs_rise) begin
            state_n = IDLE;
        end else if (byte_valid) begin
            case (state)
                CMD: begin
                    if (rx_byte == 8'h01)      state_n = ENQ;
                    else if (rx_byte == 8'h02) state_n = WSEL;
                    else                       state_n = DISCARD;
                end
                WSEL:    state_n = WADDR;
                WADDR:   if (byte_cnt == 3'd1) state_n = WDATA;
                default: state_n = state;
            endcase
        end
    end

    always_comb begin
        push  = 1'b0;
        clr   = 1'b0;
        err_n = 1'b0;
        if (cs_rise && state != IDLE && state != DISCARD && partial)
            err_n = 1'b1;
        if (byte_valid && state == CMD) begin
            if (rx_byte == 8'h03)
                clr = 1'b1;
            else if (rx_byte != 8'h01 && rx_byte != 8'h02)
                err_n = 1'b1;
        end
        if (byte_valid && state == ENQ && byte_cnt == 3'd5)
            push = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shreg       <= '0;
            e_buf       <= '0;
            a_hi        <= '0;
            sel         <= '0;
            addr        <= '0;
            w_en_r      <= 1'b0;
            w_sel_r     <= '0;
            w_addr_r    <= '0;
            w_data_r    <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= err_n;
            w_en_r      <= 1'b0;
            if (cs_fall || cs_rise) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[5:0], mosi_s};
            end
            if (byte_valid) begin
                case (state)
                    ENQ: begin
                        e_buf    <= {e_buf[31:0], rx_byte};
                        byte_cnt <= (byte_cnt == 3'd5) ? 3'd0 : byte_cnt + 3'd1;
                    end
                    WSEL: sel <= SEL_W'(rx_byte % 8'(SPRITE_NUM));
                    WADDR: begin
                        if (byte_cnt == 3'd0) begin
                            a_hi     <= rx_byte;
                            byte_cnt <= 3'd1;
                        end else begin
                            addr     <= ADDR_W'({a_hi, rx_byte});
                            byte_cnt <= 3'd0;
                        end
                    end
                    WDATA: begin
                        w_en_r   <= 1'b1;
                        w_sel_r  <= sel;
                        w_addr_r <= addr;
                        w_data_r <= rx_byte;
                        addr     <= addr + 1'b1;
                    end
                    default: byte_cnt <= '0;
                endcase
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(QUEUE_DEPTH));
    assign pop     = bus.dequeue & ~empty & ~clr;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign rnext   = rptr + 1'b1;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wptr] <= entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop)    overflow <= 1'b1;
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rnext;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head is a register: on a pop with one entry left the new
            // head can only be the entry being pushed this cycle.
            if (pop)
                head <= (count == CW'(1)) ? entry : mem[rnext];
            else if (empty && push_ok)
                head <= entry;
        end
    end

    assign bus.sprite_w_en     = w_en_r;
    assign bus.sprite_w_select = w_sel_r;
    assign bus.sprite_w_addr   = w_addr_r;
    assign bus.sprite_w_data   = w_data_r;
    assign bus.is_empty        = empty;
    assign bus.is_full         = full;
    assign bus.sprite_id       = head[47:40];
    assign bus.sprite_x        = head[39:24];
    assign bus.sprite_y        = head[23:8];
    assign bus.sprite_scale    = head[7:0];
endmodule
